// File: rtl/display_pkg.sv
// Shared types and digit codes for the 8-digit display path.
// Screen encoding is also the value driven on the screen output.
package display_pkg;

   typedef enum logic [1:0] {
      TIME  = 2'd0,
      ENV   = 2'd1,
      MSG   = 2'd2,
      BLANK = 2'd3
   } screen_e;

   localparam logic [3:0]  DIGIT_OFF      = 4'hE;
   localparam logic [3:0]  DIGIT_DASH     = 4'hF;
   localparam logic [3:0]  DIGIT_H        = 4'hA;
   localparam logic [31:0] DIGITS_ALL_OFF = {8{DIGIT_OFF}};

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module dwell_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         arstn,
   input  logic [W-1:0] load_value,
   input  logic         load,
   input  logic         enable,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/display_scheduler.sv
// Shares the 8-digit display between time, environment and message screens,
// rotating on a dwell timer with a blank gap between screens.
module display_scheduler
   import display_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 500_000_000,
   parameter int unsigned BLANK_CYCLES = 20_000_000,
   parameter int unsigned MSG_CYCLES   = 300_000_000
) (
   input  logic        clk,
   input  logic        arstn,
   input  logic [31:0] time_digits,
   input  logic [5:0]  time_dp,
   input  logic [31:0] env_digits,
   input  logic [5:0]  env_dp,
   input  logic        env_valid,
   input  logic        msg_req,
   input  logic [31:0] msg_digits,
   output logic        msg_ack,
   input  logic        next_btn,
   input  logic        rotate_en,
   output logic [31:0] dig_out,
   output logic [5:0]  dp_out,
   output logic [1:0]  screen
);

   localparam int unsigned CW = $clog2(max3(DWELL_CYCLES, BLANK_CYCLES, MSG_CYCLES)) + 1;
   localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] DWELL_RUN  = CW'(DWELL_CYCLES - 2);
   localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] MSG_LOAD   = CW'(MSG_CYCLES - 1);

   screen_e       state, next_state, ret_screen, next_ret, other_screen;
   logic          showing, env_seen, started;
   logic          capture, expire, timer_load, timer_en, expired;
   logic [CW-1:0] timer_value;
   logic [31:0]   msg_reg, dig_next;
   logic [5:0]    dp_next;

   assign showing      = (state == TIME) || (state == ENV);
   assign other_screen = (state == TIME && env_seen) ? ENV : TIME;

   dwell_timer #(.W(CW)) u_timer (
      .clk        (clk),
      .arstn      (arstn),
      .load_value (timer_value),
      .load       (timer_load),
      .enable     (timer_en),
      .expired    (expired)
   );

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state      <= TIME;
         ret_screen <= TIME;
         env_seen   <= 1'b0;
         started    <= 1'b0;
         msg_reg    <= DIGITS_ALL_OFF;
         dig_out    <= DIGITS_ALL_OFF;
         dp_out     <= '0;
         msg_ack    <= 1'b0;
         screen     <= TIME;
      end else begin
         state      <= next_state;
         ret_screen <= next_ret;
         started    <= 1'b1;
         if (env_valid) env_seen <= 1'b1;
         if (capture) msg_reg <= msg_digits;
         dig_out    <= dig_next;
         dp_out     <= dp_next;
         msg_ack    <= capture;
         screen     <= next_state;
      end
   end

   // Reset leaves the counter at zero, so the first cycle after reset loads the
   // dwell as if TIME had been entered with that cycle already counted.
   always_comb begin
      next_state  = state;
      next_ret    = ret_screen;
      capture     = 1'b0;
      timer_en    = showing ? rotate_en : 1'b1;
      expire      = expired && timer_en && started;
      timer_load  = !started;
      timer_value = rotate_en ? DWELL_RUN : DWELL_LOAD;
      if (msg_req && !(state == MSG && msg_ack)) begin
         capture    = 1'b1;
         next_state = MSG;
         if (showing) next_ret = state;
      end else if (next_btn && state != BLANK) begin
         next_state = BLANK;
         if (showing) next_ret = other_screen;
      end else if (expire) begin
         if (state == BLANK) begin
            next_state = ret_screen;
         end else begin
            next_state = BLANK;
            if (showing) next_ret = other_screen;
         end
      end
      if (capture || next_state != state) begin
         timer_load = 1'b1;
         case (next_state)
            MSG:     timer_value = MSG_LOAD;
            BLANK:   timer_value = BLANK_LOAD;
            default: timer_value = DWELL_LOAD;
         endcase
      end
   end

   always_comb begin
      dig_next = DIGITS_ALL_OFF;
      dp_next  = '0;
      case (next_state)
         TIME: begin
            dig_next = time_digits;
            dp_next  = time_dp;
         end
         ENV: begin
            dig_next = env_digits;
            dp_next  = env_dp;
         end
         MSG:     dig_next = capture ? msg_digits : msg_reg;
         default: ;
      endcase
   end

endmodule
